nixie_scan_rx: RTL and testbench

//  Receiving end of the 4-digit multiplexed display scan bus (one-hot select + 4-bit digit value).

---
 rtl/nixie_pkg.sv | 28 ++
 rtl/nixie_sat_counter.sv | 20 ++
 rtl/nixie_scan_rx.sv | 142 ++++++++++++++
 tb/tb_nixie_scan_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/nixie_pkg.sv
// Shared definitions for the 4-digit multiplexed display scan bus
// (used by both the scan transmitter and nixie_scan_rx).
package nixie_pkg;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGITS-1:0] SEL_NONE = 4'b0000;
  localparam logic [DIGITS-1:0] SEL_D0   = 4'b0001;
  localparam logic [DIGITS-1:0] SEL_D1   = 4'b0010;
  localparam logic [DIGITS-1:0] SEL_D2   = 4'b0100;
  localparam logic [DIGITS-1:0] SEL_D3   = 4'b1000;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } rx_state_t;

  // One-hot select code for slot index idx
  function automatic logic [DIGITS-1:0] sel_onehot(input logic [1:0] idx);
    logic [DIGITS-1:0] r;
    r      = SEL_NONE;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/nixie_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, cleared by reset.
module nixie_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up until all-ones, then hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/nixie_scan_rx.sv
// Receiver for the 4-digit multiplexed display scan bus. Rebuilds the four
// digit slots from one-hot select beats and commits only complete, in-order
// frames. Sequence violations pulse seq_err and bump a saturating counter.
// Optional: define NIXIE_BCD_CHECK_EN to treat digit_in > 9 as a violation.
module nixie_scan_rx
  import nixie_pkg::*;
#(
  parameter int unsigned MAX_GAP = 2,
  parameter int unsigned ERR_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIGITS-1:0]         seg_sel,
  input  logic [DIGIT_W-1:0]        digit_in,
  output logic [DIGITS*DIGIT_W-1:0] digits_out,
  output logic                      frame_done,
  output logic                      seq_err,
  output logic [ERR_W-1:0]          err_count,
  output logic                      locked
);

  localparam int unsigned GAP_W = (MAX_GAP < 1) ? 1 : $clog2(MAX_GAP + 1);

  rx_state_t                  state;
  logic [1:0]                 exp_idx;
  logic [GAP_W-1:0]           gap_cnt;
  logic [2:0][DIGIT_W-1:0]    shadow;

  logic [DIGITS-1:0]          sel_exp_c;
  logic [DIGITS-1:0]          sel_prev_c;
  logic                       digit_ok_c;
  logic                       start_c;
  logic                       viol_c;
  logic [2:0][DIGIT_W-1:0]    shadow_wr_c;
  logic [DIGITS*DIGIT_W-1:0]  commit_c;

`ifdef NIXIE_BCD_CHECK_EN
  assign digit_ok_c = (digit_in <= DIGIT_W'(9));
`else
  assign digit_ok_c = 1'b1;
`endif

  assign sel_exp_c  = sel_onehot(exp_idx);
  assign sel_prev_c = sel_onehot(exp_idx - 2'd1);
  assign start_c    = (seg_sel == SEL_D0) && digit_ok_c;
  assign commit_c   = {digit_in, shadow[2], shadow[1], shadow[0]};

  // Shadow slots with this cycle's digit written into the selected slot
  always_comb begin
    shadow_wr_c = shadow;
    for (int k = 0; k < 3; k++) begin
      if (seg_sel[k]) shadow_wr_c[k] = digit_in;
    end
  end

  // Violation detection; only COLLECT can raise errors
  always_comb begin
    viol_c = 1'b0;
    if (state == COLLECT) begin
      if (seg_sel == SEL_NONE) begin
        viol_c = (gap_cnt >= GAP_W'(MAX_GAP));
      end else if ((seg_sel == sel_exp_c) || (seg_sel == sel_prev_c)) begin
        viol_c = !digit_ok_c;
      end else begin
        viol_c = 1'b1;
      end
    end
  end

  // Frame assembly FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      exp_idx    <= 2'd1;
      gap_cnt    <= '0;
      shadow     <= '0;
      digits_out <= '0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      locked     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      case (state)
        COLLECT: begin
          if (viol_c) begin
            // Drop the partial frame; a 0001 beat immediately starts a new one
            seq_err <= 1'b1;
            locked  <= 1'b0;
            gap_cnt <= '0;
            exp_idx <= 2'd1;
            shadow  <= '0;
            if (start_c) begin
              shadow[0] <= digit_in;
              state     <= COLLECT;
            end else begin
              state <= HUNT;
            end
          end else if (seg_sel == SEL_NONE) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end else if (seg_sel == sel_exp_c) begin
            gap_cnt <= '0;
            if (seg_sel == SEL_D3) begin
              digits_out <= commit_c;
              frame_done <= 1'b1;
              locked     <= 1'b1;
              state      <= DONE;
            end else begin
              shadow  <= shadow_wr_c;
              exp_idx <= exp_idx + 2'd1;
            end
          end else begin
            // Repeat of the previous slot from a hold-style scanner
            gap_cnt <= '0;
            shadow  <= shadow_wr_c;
          end
        end
        default: begin
          // HUNT and DONE both wait for slot 0 so back-to-back frames lose no beat
          if (start_c) begin
            shadow  <= shadow_wr_c;
            exp_idx <= 2'd1;
            gap_cnt <= '0;
            state   <= COLLECT;
          end else begin
            state <= HUNT;
          end
        end
      endcase
    end
  end

  nixie_sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (viol_c),
    .count(err_count)
  );

endmodule

// File: tb/tb_nixie_scan_rx.sv
// Self-checking bench for nixie_scan_rx: directed scenarios plus randomized
// scan traffic, compared every cycle against a frame-level reference model.
module tb_nixie_scan_rx;

  localparam int unsigned MAX_GAP = 2;
  localparam int unsigned ERR_W   = 8;
  localparam int unsigned ERR_W_S = 2;
  localparam int          CNT_MAX   = (1 << ERR_W) - 1;
  localparam int          CNT_MAX_S = (1 << ERR_W_S) - 1;
`ifdef NIXIE_BCD_CHECK_EN
  localparam int DIG_MAX = 9;
`else
  localparam int DIG_MAX = 15;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         seg_sel;
  logic [3:0]         digit_in;
  logic [15:0]        digits_out, digits_out_s;
  logic               frame_done, frame_done_s;
  logic               seq_err, seq_err_s;
  logic [ERR_W-1:0]   err_count;
  logic [ERR_W_S-1:0] err_count_s;
  logic               locked, locked_s;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_in;
  int          m_pos, m_gap;
  logic [3:0]  m_buf [4];
  logic [15:0] m_digits;
  bit          m_fd, m_se, m_locked;
  int          m_cnt, m_cnt_s;

  always #5 clk = ~clk;

  nixie_scan_rx #(.MAX_GAP(MAX_GAP), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .seg_sel(seg_sel), .digit_in(digit_in),
    .digits_out(digits_out), .frame_done(frame_done), .seq_err(seq_err),
    .err_count(err_count), .locked(locked)
  );

  nixie_scan_rx #(.MAX_GAP(MAX_GAP), .ERR_W(ERR_W_S)) dut_s (
    .clk(clk), .rst(rst), .seg_sel(seg_sel), .digit_in(digit_in),
    .digits_out(digits_out_s), .frame_done(frame_done_s), .seq_err(seq_err_s),
    .err_count(err_count_s), .locked(locked_s)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in = 0; m_pos = 0; m_gap = 0;
    for (int i = 0; i < 4; i++) m_buf[i] = 4'h0;
    m_digits = 16'h0; m_fd = 0; m_se = 0; m_locked = 0;
    m_cnt = 0; m_cnt_s = 0;
  endtask

  task automatic model_start(input logic [3:0] s, input logic [3:0] d, input bit ok);
    if (s == 4'b0001 && ok) begin
      m_in = 1; m_pos = 1; m_gap = 0; m_buf[0] = d;
    end
  endtask

  // One sampled beat of the scan bus, applied to the frame-level model
  task automatic model_step(input logic [3:0] s, input logic [3:0] d);
    bit ok, bad;
    ok = 1'b1;
`ifdef NIXIE_BCD_CHECK_EN
    ok = (d <= 4'd9);
`endif
    m_fd = 0; m_se = 0; bad = 0;
    if (!m_in) begin
      model_start(s, d, ok);
    end else begin
      if (s == 4'b0000) begin
        m_gap++;
        if (m_gap > MAX_GAP) bad = 1;
      end else if (s == 4'(1 << m_pos)) begin
        if (!ok) bad = 1;
        else begin
          m_buf[m_pos] = d; m_gap = 0; m_pos++;
          if (m_pos == 4) begin
            m_digits = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
            m_fd = 1; m_locked = 1; m_in = 0;
          end
        end
      end else if (s == 4'(1 << (m_pos - 1))) begin
        if (!ok) bad = 1;
        else begin
          m_buf[m_pos - 1] = d; m_gap = 0;
        end
      end else begin
        bad = 1;
      end
      if (bad) begin
        m_se = 1; m_locked = 0; m_in = 0;
        if (m_cnt < CNT_MAX) m_cnt++;
        if (m_cnt_s < CNT_MAX_S) m_cnt_s++;
        model_start(s, d, ok);
      end
    end
  endtask

  task automatic check_all();
    check_eq("digits_out", int'(digits_out), int'(m_digits));
    check_eq("frame_done", int'(frame_done), int'(m_fd));
    check_eq("seq_err",    int'(seq_err),    int'(m_se));
    check_eq("err_count",  int'(err_count),  m_cnt);
    check_eq("locked",     int'(locked),     int'(m_locked));
    check_eq("digits_out_s", int'(digits_out_s), int'(m_digits));
    check_eq("seq_err_s",    int'(seq_err_s),    int'(m_se));
    check_eq("err_count_s",  int'(err_count_s),  m_cnt_s);
  endtask

  task automatic beat(input logic [3:0] s, input logic [3:0] d);
    seg_sel  = s;
    digit_in = d;
    @(posedge clk);
    model_step(s, d);
    #1 check_all();
  endtask

  task automatic frame(input logic [3:0] d0, input logic [3:0] d1,
                       input logic [3:0] d2, input logic [3:0] d3);
    beat(4'b0001, d0); beat(4'b0010, d1); beat(4'b0100, d2); beat(4'b1000, d3);
  endtask

  initial begin
    int n_fd;
    int gen_k;
    int r;
    logic [3:0] s;

    // Reset state
    rst = 1'b1; seg_sel = 4'h0; digit_in = 4'h0;
    model_reset();
    #12 check_all();
    rst = 1'b0;

    // Basic frame
    frame(4'd5, 4'd6, 4'd7, 4'd8);
    check_eq("t1_digits", int'(digits_out), 32'h8765);
    check_eq("t1_frame_done", int'(frame_done), 1);
    check_eq("t1_locked", int'(locked), 1);

    // 20 back-to-back frames with changing digits
    n_fd = 0;
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 4; k++) begin
        beat(4'(1 << k), 4'($urandom_range(0, DIG_MAX)));
        if (frame_done) n_fd++;
      end
    end
    check_eq("t2_frames", n_fd, 20);
    check_eq("t2_err_count", int'(err_count), 0);

    // Skip inside a frame, then recover
    beat(4'b0001, 4'd1); beat(4'b0010, 4'd2); beat(4'b1000, 4'd3);
    check_eq("t3_err_count", int'(err_count), 1);
    check_eq("t3_locked", int'(locked), 0);
    frame(4'd4, 4'd3, 4'd2, 4'd1);
    check_eq("t3_recover", int'(digits_out), 32'h1234);

    // Gaps: two tolerated, three rejected; hold-style repeat accepted
    beat(4'b0001, 4'd9); beat(4'b0000, 4'd0); beat(4'b0000, 4'd0);
    beat(4'b0010, 4'd8); beat(4'b0010, 4'd7); beat(4'b0100, 4'd6); beat(4'b1000, 4'd5);
    check_eq("t4_gap_ok", int'(digits_out), 32'h5679);
    beat(4'b0001, 4'd1); beat(4'b0000, 4'd0); beat(4'b0000, 4'd0); beat(4'b0000, 4'd0);
    check_eq("t4_gap_err", int'(seq_err), 1);

    // Non-one-hot select, and saturation of the narrow counter
    for (int i = 0; i < 5; i++) begin
      beat(4'b0001, 4'd3); beat(4'b0011, 4'd3);
    end
    check_eq("t5_sat", int'(err_count_s), 3);

    // Digit 0xA in a frame
    frame(4'd1, 4'd2, 4'hA, 4'd3);
    frame(4'd1, 4'd2, 4'd3, 4'd4);

    // Asynchronous reset during the slot-2 beat
    beat(4'b0001, 4'd6); beat(4'b0010, 4'd6);
    seg_sel = 4'b0100; digit_in = 4'd6;
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    check_eq("t7_locked", int'(locked), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    beat(4'b0100, 4'd7); beat(4'b1000, 4'd7);
    frame(4'd2, 4'd4, 4'd6, 4'd8);
    check_eq("t7_fresh", int'(digits_out), 32'h8642);

    // Randomized scan traffic with faults mixed in
    gen_k = 0;
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        s = 4'(1 << gen_k);
        gen_k = (gen_k + 1) % 4;
      end else if (r < 80) begin
        s = 4'b0000;
      end else if (r < 86) begin
        s = 4'(1 << ((gen_k + 3) % 4));
      end else begin
        s = 4'($urandom_range(0, 15));
      end
      beat(s, 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
